lsu_wb_ctrl: RTL and testbench

- Writeback-stage load/store controller; successor to the combinational writeback LSU path.
- Adds a registered request/grant/rvalid handshake FSM, byte-lane alignment by address offset, misalignment detection and a parametrised bus-timeout watchdog.
- Sits between the execute/writeback pipeline register and the data-memory port.
- Drives the register-file write data and valid, and stalls the pipeline while a transaction is open.

---
 rtl/lsu_wb_ctrl_pkg.sv | 22 ++
 rtl/lsu_load_align.sv | 19 +
 rtl/lsu_wb_ctrl.sv | 130 +++++++++++++
 tb/tb_lsu_wb_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_wb_ctrl_pkg.sv
// lsu_wb_ctrl_pkg: shared load/store types, FSM states and byte-enable helpers
package lsu_wb_ctrl_pkg;
   localparam int DATA_W = 32;
   localparam int BE_WIDTH = DATA_W / 8;
   typedef enum logic [2:0] {
      LD_NONE = 3'b000,
      LD_LB   = 3'b001,
      LD_LH   = 3'b010,
      LD_LW   = 3'b100,
      LD_LBU  = 3'b101,
      LD_LHU  = 3'b110
   } load_type_t;
   typedef enum logic [1:0] {ST_NONE, ST_SB, ST_SH, ST_SW} store_type_t;
   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} lsu_state_t;
   // size code shared by loads and stores: 01 byte, 10 half, 00/11 word
   function automatic logic [BE_WIDTH-1:0] be_mask(input logic [1:0] sz, input logic [1:0] off);
      return sz == 2'b01 ? 4'b0001 << off : sz == 2'b10 ? 4'b0011 << off : 4'b1111;
   endfunction
   function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] off);
      return sz == 2'b01 || (sz == 2'b10 ? !off[0] : off == 2'b00);
   endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed load lane and sign/zero-extends it
module lsu_load_align
   import lsu_wb_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        offset,
   input  logic [2:0]        load_type,
   output logic [DATA_W-1:0] data
);
   logic [DATA_W-1:0] lane;
   logic              sgn;
   // shift the addressed byte to lane 0, then extend to register width
   always_comb begin
      lane = rdata >> {offset, 3'b000};
      sgn = load_type == LD_LB || load_type == LD_LH;
      data = (load_type == LD_LB || load_type == LD_LBU) ? {{24{sgn & lane[7]}}, lane[7:0]} :
             (load_type == LD_LH || load_type == LD_LHU) ? {{16{sgn & lane[15]}}, lane[15:0]} : lane;
   end
endmodule

// File: rtl/lsu_wb_ctrl.sv
// lsu_wb_ctrl: writeback load/store controller with req/gnt/rvalid FSM and bus watchdog
module lsu_wb_ctrl
   import lsu_wb_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] wb_data_i,
   input  logic [DATA_WIDTH-1:0] store_data_i,
   input  logic [2:0]            load_type_i,
   input  logic [1:0]            store_type_i,
   output logic                  data_req_o,
   output logic [ADDR_WIDTH-1:0] data_addr_o,
   output logic                  data_we_o,
   output logic [3:0]            data_be_o,
   output logic [DATA_WIDTH-1:0] data_wdata_o,
   input  logic                  data_gnt_i,
   input  logic                  data_rvalid_i,
   input  logic [DATA_WIDTH-1:0] data_rdata_i,
   output logic [DATA_WIDTH-1:0] reg_wdata_o,
   output logic                  reg_wdata_valid_o,
   output logic                  busy_o,
   output logic                  misaligned_o,
   output logic                  bus_err_o,
   output logic                  load_flag_o
);
   localparam int TO_CNT_W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TO_CNT_W-1:0] TO_MAX = TO_CNT_W'(TIMEOUT_CYCLES);

   if (DATA_WIDTH != 32) begin : g_width_chk
      $error("lsu_wb_ctrl supports DATA_WIDTH == 32 only");
   end

   lsu_state_t            state;
   logic [TO_CNT_W-1:0]   cnt, cnt_inc;
   logic [1:0]            off, off_q, sz;
   logic [2:0]            lt_q;
   logic                  is_ld, mem_op, aligned, timeout, done;
   logic [DATA_WIDTH-1:0] ld_data, st_fmt;

   lsu_load_align u_align (
      .rdata     (data_rdata_i),
      .offset    (off_q),
      .load_type (lt_q),
      .data      (ld_data)
   );

   // request decode, watchdog compare and same-cycle writeback/stall outputs
   always_comb begin
      off = wb_data_i[1:0];
      is_ld = |load_type_i;
      mem_op = is_ld || |store_type_i;
      sz = is_ld ? load_type_i[1:0] : store_type_i;
      aligned = is_aligned(sz, off);
      st_fmt = store_type_i == ST_SB ? {4{store_data_i[7:0]}} :
               store_type_i == ST_SH ? {2{store_data_i[15:0]}} : store_data_i;
      cnt_inc = cnt == TO_MAX ? cnt : cnt + TO_CNT_W'(1);
      timeout = TIMEOUT_CYCLES != 0 && cnt_inc == TO_MAX;
      done = data_rvalid_i && (state == WAIT_RVALID || (state == WAIT_GNT && data_gnt_i));
      busy_o = state != IDLE || (valid_i && mem_op && aligned);
      reg_wdata_o = state == IDLE ? wb_data_i : ld_data;
      reg_wdata_valid_o = rst_n && (state == IDLE ? valid_i && !mem_op : done && !data_we_o);
      load_flag_o = is_ld;
   end

   // transaction FSM with registered bus outputs, error pulses and watchdog counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         data_req_o <= 1'b0;
         data_addr_o <= '0;
         data_we_o <= 1'b0;
         data_be_o <= '0;
         data_wdata_o <= '0;
         misaligned_o <= 1'b0;
         bus_err_o <= 1'b0;
         cnt <= '0;
         off_q <= '0;
         lt_q <= '0;
      end else begin
         misaligned_o <= 1'b0;
         bus_err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_i && mem_op && aligned) begin
                  state <= WAIT_GNT;
                  data_req_o <= 1'b1;
                  data_addr_o <= {wb_data_i[ADDR_WIDTH-1:2], 2'b00};
                  data_we_o <= !is_ld;
                  data_be_o <= be_mask(sz, off);
                  data_wdata_o <= is_ld ? '0 : st_fmt;
                  off_q <= off;
                  lt_q <= load_type_i;
                  cnt <= '0;
               end else if (valid_i && mem_op) begin
                  misaligned_o <= 1'b1;
               end
            end
            WAIT_GNT: begin
               if (data_gnt_i) begin
                  data_req_o <= 1'b0;
                  cnt <= '0;
                  state <= data_rvalid_i ? IDLE : WAIT_RVALID;
               end else if (timeout) begin
                  data_req_o <= 1'b0;
                  bus_err_o <= 1'b1;
                  state <= IDLE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            WAIT_RVALID: begin
               if (data_rvalid_i) begin
                  state <= IDLE;
               end else if (timeout) begin
                  bus_err_o <= 1'b1;
                  state <= IDLE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_wb_ctrl.sv
// tb_lsu_wb_ctrl: scoreboard bench for the writeback load/store controller
module tb_lsu_wb_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_i = 1'b0;
   logic [31:0] wb_data_i = '0;
   logic [31:0] store_data_i = '0;
   logic [2:0]  load_type_i = '0;
   logic [1:0]  store_type_i = '0;
   logic        data_req_o;
   logic [31:0] data_addr_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i = 1'b0;
   logic        data_rvalid_i = 1'b0;
   logic [31:0] data_rdata_i = '0;
   logic [31:0] reg_wdata_o;
   logic        reg_wdata_valid_o;
   logic        busy_o;
   logic        misaligned_o;
   logic        bus_err_o;
   logic        load_flag_o;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] sb[$];

   lsu_wb_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .valid_i           (valid_i),
      .wb_data_i         (wb_data_i),
      .store_data_i      (store_data_i),
      .load_type_i       (load_type_i),
      .store_type_i      (store_type_i),
      .data_req_o        (data_req_o),
      .data_addr_o       (data_addr_o),
      .data_we_o         (data_we_o),
      .data_be_o         (data_be_o),
      .data_wdata_o      (data_wdata_o),
      .data_gnt_i        (data_gnt_i),
      .data_rvalid_i     (data_rvalid_i),
      .data_rdata_i      (data_rdata_i),
      .reg_wdata_o       (reg_wdata_o),
      .reg_wdata_valid_o (reg_wdata_valid_o),
      .busy_o            (busy_o),
      .misaligned_o      (misaligned_o),
      .bus_err_o         (bus_err_o),
      .load_flag_o       (load_flag_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] load_model(input logic [31:0] rd, input logic [1:0] off, input logic [2:0] lt);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = off[1] ? rd[31:16] : rd[15:0];
      case (lt)
         3'b001:  return {{24{b[7]}}, b};
         3'b101:  return {24'h0, b};
         3'b010:  return {{16{h[15]}}, h};
         3'b110:  return {16'h0, h};
         default: return rd;
      endcase
   endfunction

   always @(negedge clk) begin
      if (reg_wdata_valid_o) begin
         if (sb.size() == 0) check("sb_unexpected", {31'h0, reg_wdata_valid_o}, 32'h0);
         else check("sb_data", reg_wdata_o, sb.pop_front());
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input logic [31:0] d);
      valid_i = 1'b1;
      wb_data_i = d;
      load_type_i = 3'b000;
      store_type_i = 2'b00;
      sb.push_back(d);
      #1;
      check("alu_valid", {31'h0, reg_wdata_valid_o}, 32'h1);
      check("alu_busy", {31'h0, busy_o}, 32'h0);
      step;
      valid_i = 1'b0;
   endtask

   task automatic txn(input logic [31:0] addr, input logic [2:0] lt, input logic [1:0] st,
                      input logic [31:0] sd, input logic [31:0] rd, input int gdly,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd);
      valid_i = 1'b1;
      wb_data_i = addr;
      load_type_i = lt;
      store_type_i = st;
      store_data_i = sd;
      if (lt != 3'b000) sb.push_back(load_model(rd, addr[1:0], lt));
      #1;
      check("accept_busy", {31'h0, busy_o}, 32'h1);
      step;
      valid_i = 1'b0;
      load_type_i = 3'b000;
      store_type_i = 2'b00;
      for (int i = 0; i <= gdly; i++) begin
         check("req", {31'h0, data_req_o}, 32'h1);
         check("addr", data_addr_o, {addr[31:2], 2'b00});
         check("be", {28'h0, data_be_o}, {28'h0, exp_be});
         check("we", {31'h0, data_we_o}, {31'h0, lt == 3'b000});
         if (lt == 3'b000) check("wdata", data_wdata_o, exp_wd);
         data_gnt_i = (i == gdly);
         step;
      end
      data_gnt_i = 1'b0;
      check("req_drop", {31'h0, data_req_o}, 32'h0);
      check("busy_wait", {31'h0, busy_o}, 32'h1);
      data_rvalid_i = 1'b1;
      data_rdata_i = rd;
      #1;
      check("rvalid_wr", {31'h0, reg_wdata_valid_o}, {31'h0, lt != 3'b000});
      step;
      data_rvalid_i = 1'b0;
      check("busy_end", {31'h0, busy_o}, 32'h0);
   endtask

   task automatic mis(input logic [31:0] addr, input logic [2:0] lt, input logic [1:0] st);
      valid_i = 1'b1;
      wb_data_i = addr;
      load_type_i = lt;
      store_type_i = st;
      #1;
      check("mis_busy0", {31'h0, busy_o}, 32'h0);
      check("mis_nowr", {31'h0, reg_wdata_valid_o}, 32'h0);
      check("load_flag", {31'h0, load_flag_o}, {31'h0, lt != 3'b000});
      step;
      valid_i = 1'b0;
      load_type_i = 3'b000;
      store_type_i = 2'b00;
      check("mis_pulse", {31'h0, misaligned_o}, 32'h1);
      check("mis_req", {31'h0, data_req_o}, 32'h0);
      check("mis_busy1", {31'h0, busy_o}, 32'h0);
      step;
      check("mis_end", {31'h0, misaligned_o}, 32'h0);
      check("mis_req2", {31'h0, data_req_o}, 32'h0);
   endtask

   initial begin
      step;
      step;
      check("rst_req", {31'h0, data_req_o}, 32'h0);
      check("rst_addr", data_addr_o, 32'h0);
      check("rst_be", {28'h0, data_be_o}, 32'h0);
      check("rst_wdata", data_wdata_o, 32'h0);
      check("rst_we", {31'h0, data_we_o}, 32'h0);
      check("rst_mis", {31'h0, misaligned_o}, 32'h0);
      check("rst_err", {31'h0, bus_err_o}, 32'h0);
      check("rst_busy", {31'h0, busy_o}, 32'h0);
      rst_n = 1'b1;
      step;
      alu(32'h1234_ABCD);
      alu(32'h0000_0001);
      txn(32'h1003, 3'b101, 2'b00, 32'h0, 32'h80FF_0000, 0, 4'b1000, 32'h0);
      txn(32'h2002, 3'b010, 2'b00, 32'h0, 32'h8001_1234, 0, 4'b1100, 32'h0);
      txn(32'h0010, 3'b000, 2'b10, 32'hABCD_5678, 32'h0, 3, 4'b0011, 32'h5678_5678);
      txn(32'h0021, 3'b001, 2'b00, 32'h0, 32'h0000_F700, 1, 4'b0010, 32'h0);
      txn(32'h0032, 3'b110, 2'b00, 32'h0, 32'hC3A5_0000, 0, 4'b1100, 32'h0);
      txn(32'h0044, 3'b100, 2'b00, 32'h0, 32'h1234_5678, 2, 4'b1111, 32'h0);
      txn(32'h0053, 3'b000, 2'b01, 32'h0000_00EE, 32'h0, 0, 4'b1000, 32'hEEEE_EEEE);
      txn(32'h0060, 3'b000, 2'b11, 32'hCAFE_F00D, 32'h0, 1, 4'b1111, 32'hCAFE_F00D);
      txn(32'h0072, 3'b010, 2'b11, 32'hFFFF_FFFF, 32'h7FFF_0000, 0, 4'b1100, 32'h0);
      mis(32'h0006, 3'b100, 2'b00);
      mis(32'h0011, 3'b000, 2'b10);
      mis(32'h0003, 3'b010, 2'b00);
      mis(32'h0002, 3'b000, 2'b11);
      // grant and response in the same cycle
      valid_i = 1'b1;
      wb_data_i = 32'h0080;
      load_type_i = 3'b100;
      sb.push_back(32'h1122_3344);
      step;
      valid_i = 1'b0;
      load_type_i = 3'b000;
      check("same_req", {31'h0, data_req_o}, 32'h1);
      data_gnt_i = 1'b1;
      data_rvalid_i = 1'b1;
      data_rdata_i = 32'h1122_3344;
      #1;
      check("same_wr", {31'h0, reg_wdata_valid_o}, 32'h1);
      step;
      data_gnt_i = 1'b0;
      data_rvalid_i = 1'b0;
      check("same_busy", {31'h0, busy_o}, 32'h0);
      check("same_req0", {31'h0, data_req_o}, 32'h0);
      // watchdog expiry while waiting for rvalid
      valid_i = 1'b1;
      wb_data_i = 32'h0100;
      load_type_i = 3'b100;
      step;
      valid_i = 1'b0;
      load_type_i = 3'b000;
      data_gnt_i = 1'b1;
      step;
      data_gnt_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("to_rv_noerr", {31'h0, bus_err_o}, 32'h0);
         check("to_rv_busy", {31'h0, busy_o}, 32'h1);
         step;
      end
      check("to_rv_err", {31'h0, bus_err_o}, 32'h1);
      check("to_rv_idle", {31'h0, busy_o}, 32'h0);
      step;
      check("to_rv_pulse", {31'h0, bus_err_o}, 32'h0);
      data_rvalid_i = 1'b1;
      data_rdata_i = 32'hBAD0_BAD0;
      #1;
      check("late_rv", {31'h0, reg_wdata_valid_o}, 32'h0);
      step;
      data_rvalid_i = 1'b0;
      // watchdog expiry while waiting for grant
      valid_i = 1'b1;
      wb_data_i = 32'h0200;
      store_type_i = 2'b11;
      step;
      valid_i = 1'b0;
      store_type_i = 2'b00;
      for (int i = 0; i < 4; i++) begin
         check("to_gnt_req", {31'h0, data_req_o}, 32'h1);
         check("to_gnt_noerr", {31'h0, bus_err_o}, 32'h0);
         step;
      end
      check("to_gnt_err", {31'h0, bus_err_o}, 32'h1);
      check("to_gnt_req0", {31'h0, data_req_o}, 32'h0);
      check("to_gnt_idle", {31'h0, busy_o}, 32'h0);
      step;
      // reset abandons an open transaction
      valid_i = 1'b1;
      wb_data_i = 32'h0300;
      store_type_i = 2'b11;
      store_data_i = 32'h0000_0001;
      step;
      valid_i = 1'b0;
      store_type_i = 2'b00;
      check("rst_mid_req", {31'h0, data_req_o}, 32'h1);
      rst_n = 1'b0;
      step;
      check("rst_mid_req0", {31'h0, data_req_o}, 32'h0);
      check("rst_mid_be", {28'h0, data_be_o}, 32'h0);
      check("rst_mid_wd", data_wdata_o, 32'h0);
      rst_n = 1'b1;
      alu(32'hDEAD_BEEF);
      data_rvalid_i = 1'b1;
      #1;
      check("rst_late_rv", {31'h0, reg_wdata_valid_o}, 32'h0);
      check("rst_late_busy", {31'h0, busy_o}, 32'h0);
      step;
      data_rvalid_i = 1'b0;
      step;
      check("sb_empty", sb.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
